// File: rtl/aes_enc_scheduler.sv
// AES-128 encryption front-end scheduler.
// Round-robin issue, owner tags, response FIFO, credit and key-drain sequencing.
module aes_enc_scheduler #(
    parameter int NREQ       = 2,
    parameter int PIPE_LAT   = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128-1:0]   req_data,
    output logic                  pt_valid,
    output logic [127:0]          pt_data,
    input  logic [127:0]          ct_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [127:0]          rsp_data,
    input  logic                  key_upd_req,
    output logic                  key_upd_ack,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2,
        WAIT  = 2'd3
    } st_e;

    st_e                st_q;
    logic [IDW-1:0]     rr_q;
    logic [CW-1:0]      outst_q;
    logic [PIPE_LAT:1]  tag_v_q;
    logic [IDW-1:0]     tag_id_q [1:PIPE_LAT];
    logic [IDW+127:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]        wptr_q;
    logic [AW:0]        rptr_q;

    logic [IDW-1:0]     grant;
    logic [IDW-1:0]     rr_d;
    logic               any_v;
    logic               issue_ok;
    logic               issue;
    logic               fifo_wr;
    logic               fifo_full;
    logic               pop;
    logic [IDW+127:0]   head;
    int unsigned        idx;

    // Round-robin search starting at rr; lowest offset wins
    always_comb begin
        grant = rr_q;
        any_v = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                grant = IDW'(idx);
                any_v = 1'b1;
            end
        end
    end

    // Issue only in RUN with a free credit; held off during reset
    always_comb begin
        issue_ok  = reset && (st_q == RUN) && !key_upd_req
                  && (outst_q < CW'(FIFO_DEPTH));
        issue     = issue_ok && any_v;
        req_ready = issue ? (NREQ'(1) << grant) : '0;
        pt_valid  = issue;
        pt_data   = issue ? req_data[128*int'(grant) +: 128] : '0;
        rr_d      = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end

    // FIFO status and head decode
    always_comb begin
        fifo_wr   = tag_v_q[PIPE_LAT];
        fifo_full = (wptr_q[AW] != rptr_q[AW])
                  && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rsp_valid = (wptr_q != rptr_q);
        pop       = rsp_valid && rsp_ready;
        head      = mem_q[rptr_q[AW-1:0]];
        rsp_id    = rsp_valid ? head[IDW+127:128] : '0;
        rsp_data  = rsp_valid ? head[127:0] : '0;
        busy      = (outst_q != '0);
    end

    // Arbiter pointer and outstanding-credit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= '0;
            outst_q <= '0;
        end else begin
            if (issue) rr_q <= rr_d;
            if (issue && !pop) outst_q <= outst_q + CW'(1);
            else if (!issue && pop) outst_q <= outst_q - CW'(1);
        end
    end

    // Owner tags travel alongside the datapath stages
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_q <= '0;
            for (int k = 1; k <= PIPE_LAT; k++) tag_id_q[k] <= '0;
        end else begin
            tag_v_q     <= {tag_v_q[PIPE_LAT-1:1], issue};
            tag_id_q[1] <= grant;
            for (int k = 2; k <= PIPE_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    // Response FIFO pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (fifo_wr) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Response FIFO storage; contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wptr_q[AW-1:0]] <= {tag_id_q[PIPE_LAT], ct_in};
    end

    // Key-update sequencer: stop issue, drain, ack once, wait for release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= RUN;
        end else begin
            unique case (st_q)
                RUN:   if (key_upd_req) st_q <= DRAIN;
                DRAIN: if (tag_v_q == '0) st_q <= ACK;
                ACK:   st_q <= WAIT;
                WAIT:  if (!key_upd_req) st_q <= RUN;
                default: st_q <= RUN;
            endcase
        end
    end

    assign key_upd_ack = (st_q == ACK);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_wr && fifo_full));

endmodule
